// File: rtl/trail_pkg.sv
// Shared types, grid geometry and the pixel-to-cell index helper for the light-wall grid.
package trail_pkg;

   localparam int PIX_W      = 640;
   localparam int PIX_H      = 480;
   localparam int CELL_SHIFT = 2;
   localparam int GRID_W     = PIX_W >> CELL_SHIFT;
   localparam int GRID_H     = PIX_H >> CELL_SHIFT;
   localparam int CELL_COUNT = GRID_W * GRID_H;
   localparam int ADDR_W     = 15;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_BLUE  = 2'd1,
      CELL_RED   = 2'd2
   } cell_t;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_RD_B,
      ST_CK_B,
      ST_RD_R,
      ST_CK_R
   } state_t;

   // row * 160 built from shifts: 160 = 128 + 32
   function automatic logic [ADDR_W-1:0] cell_index(input logic [9:0] x, input logic [9:0] y);
      logic [ADDR_W-1:0] cx;
      logic [ADDR_W-1:0] cy;
      cx = ADDR_W'(x >> CELL_SHIFT);
      cy = ADDR_W'(y >> CELL_SHIFT);
      return (cy << 7) + (cy << 5) + cx;
   endfunction

   function automatic logic pos_valid(input logic [9:0] x, input logic [9:0] y);
      return (x < 10'(PIX_W)) && (y < 10'(PIX_H));
   endfunction

endpackage

// File: rtl/trail_grid_if.sv
// Bike positions, frame/round control, VGA read request and status returned by the trail grid.
interface trail_grid_if;

   logic       frame_clk;
   logic       round_start;
   logic [9:0] Blue_X;
   logic [9:0] Blue_Y;
   logic [9:0] Red_X;
   logic [9:0] Red_Y;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       busy;
   logic       trail_hit_blue;
   logic       trail_hit_red;
   logic [1:0] cell_color;

   modport master (
      output frame_clk, round_start, Blue_X, Blue_Y, Red_X, Red_Y, DrawX, DrawY,
      input  busy, trail_hit_blue, trail_hit_red, cell_color
   );

   modport slave (
      input  frame_clk, round_start, Blue_X, Blue_Y, Red_X, Red_Y, DrawX, DrawY,
      output busy, trail_hit_blue, trail_hit_red, cell_color
   );

endinterface

// File: rtl/trail_ram.sv
// Simple dual-port synchronous RAM: port A read/write for the update FSM, port B read-only for video.
module trail_ram #(
   parameter int DEPTH  = 19200,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 2
) (
   input  logic              Clk,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge Clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
      rdata_a <= mem[addr_a];
   end

   always_ff @(posedge Clk) begin
      rdata_b <= mem[addr_b];
   end

endmodule

// File: rtl/trail_grid.sv
// Light-wall bitmap: stamps each bike's cell every frame, flags trail hits, serves the colour mapper.
// Build option TRAIL_SELF_HIT_EN: any lit cell other than the bike's current one counts as a hit.
module trail_grid
   import trail_pkg::*;
(
   input logic         Clk,
   input logic         Reset_n,
   trail_grid_if.slave bus
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [ADDR_W-1:0] last_b, last_b_nxt;
   logic [ADDR_W-1:0] last_r, last_r_nxt;
   logic              hit_b, hit_b_nxt;
   logic              hit_r, hit_r_nxt;
   logic [1:0]        frame_q;
   logic              tick;
   logic              latch;
   logic              vld_b, vld_r;
   logic [ADDR_W-1:0] cell_b, cell_r;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [1:0]        ram_wdata;
   logic [1:0]        ram_q;
   logic              lit_b, lit_r;

   logic              draw_ok;
   logic [ADDR_W-1:0] draw_addr;
   logic              draw_vld_p1;
   logic [1:0]        draw_q_p1;

   assign tick = frame_q[0] & ~frame_q[1];

`ifdef TRAIL_SELF_HIT_EN
   assign lit_b = (ram_q != CELL_EMPTY);
   assign lit_r = (ram_q != CELL_EMPTY);
`else
   assign lit_b = (ram_q == CELL_RED);
   assign lit_r = (ram_q == CELL_BLUE);
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= ST_CLEAR;
         addr    <= '0;
         last_b  <= '1;
         last_r  <= '1;
         hit_b   <= 1'b0;
         hit_r   <= 1'b0;
         frame_q <= 2'b00;
         vld_b   <= 1'b0;
         vld_r   <= 1'b0;
      end else begin
         state   <= state_nxt;
         addr    <= addr_nxt;
         last_b  <= last_b_nxt;
         last_r  <= last_r_nxt;
         hit_b   <= hit_b_nxt;
         hit_r   <= hit_r_nxt;
         frame_q <= {frame_q[0], bus.frame_clk};
         if (latch) begin
            vld_b <= pos_valid(bus.Blue_X, bus.Blue_Y);
            vld_r <= pos_valid(bus.Red_X, bus.Red_Y);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (latch) begin
         cell_b <= cell_index(bus.Blue_X, bus.Blue_Y);
         cell_r <= cell_index(bus.Red_X, bus.Red_Y);
      end
   end

   always_comb begin
      state_nxt  = state;
      addr_nxt   = addr;
      last_b_nxt = last_b;
      last_r_nxt = last_r;
      hit_b_nxt  = hit_b;
      hit_r_nxt  = hit_r;
      latch      = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = addr;
      ram_wdata  = CELL_EMPTY;
      unique case (state)
         ST_CLEAR: begin
            ram_we   = 1'b1;
            addr_nxt = addr + 1'b1;
            if (addr == ADDR_W'(CELL_COUNT - 1)) begin
               addr_nxt   = '0;
               hit_b_nxt  = 1'b0;
               hit_r_nxt  = 1'b0;
               last_b_nxt = '1;
               last_r_nxt = '1;
               state_nxt  = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (tick) begin
               latch     = 1'b1;
               state_nxt = ST_RD_B;
            end
         end
         ST_RD_B: begin
            ram_addr  = cell_b;
            state_nxt = ST_CK_B;
         end
         ST_CK_B: begin
            ram_addr = cell_b;
            if (vld_b) begin
               ram_we     = 1'b1;
               ram_wdata  = CELL_BLUE;
               last_b_nxt = cell_b;
               if (lit_b && (cell_b != last_b)) hit_b_nxt = 1'b1;
            end
            state_nxt = ST_RD_R;
         end
         ST_RD_R: begin
            ram_addr  = cell_r;
            state_nxt = ST_CK_R;
         end
         ST_CK_R: begin
            ram_addr = cell_r;
            if (vld_r) begin
               ram_we     = 1'b1;
               ram_wdata  = CELL_RED;
               last_r_nxt = cell_r;
               if (lit_r && (cell_r != last_r)) hit_r_nxt = 1'b1;
            end
            // head-on collision in one cell counts against both riders
            if (vld_b && vld_r && (cell_b == cell_r)) begin
               hit_b_nxt = 1'b1;
               hit_r_nxt = 1'b1;
            end
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_CLEAR;
      endcase
      if (bus.round_start) begin
         ram_we    = 1'b0;
         addr_nxt  = '0;
         state_nxt = ST_CLEAR;
      end
   end

   trail_ram #(
      .DEPTH  (CELL_COUNT),
      .ADDR_W (ADDR_W),
      .DATA_W (2)
   ) u_ram (
      .Clk     (Clk),
      .we_a    (ram_we),
      .addr_a  (ram_addr),
      .wdata_a (ram_wdata),
      .rdata_a (ram_q),
      .addr_b  (draw_addr),
      .rdata_b (draw_q_p1)
   );

   // ---- video read: p0 address, p1 registered data ----
   assign draw_ok   = pos_valid(bus.DrawX, bus.DrawY);
   assign draw_addr = draw_ok ? cell_index(bus.DrawX, bus.DrawY) : '0;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) draw_vld_p1 <= 1'b0;
      else          draw_vld_p1 <= draw_ok;
   end

   assign bus.cell_color     = draw_vld_p1 ? draw_q_p1 : CELL_EMPTY;
   assign bus.busy           = (state != ST_IDLE);
   assign bus.trail_hit_blue = hit_b;
   assign bus.trail_hit_red  = hit_r;

endmodule

// File: tb/tb_trail_grid.sv
// Scoreboard bench for trail_grid: stimulus pushes expected values, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_trail_grid;
   import trail_pkg::*;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   always #10 Clk = ~Clk;

   trail_grid_if bus();

   trail_grid dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      string name;
      int    kind;   // 0 cell_color, 1 hit blue, 2 hit red, 3 busy
      int    exp;
   } exp_t;

   exp_t sb[$];
   logic probe = 1'b0;
   logic probe_d = 1'b0;

`ifdef TRAIL_SELF_HIT_EN
   localparam int SELF_HIT_EXP = 1;
`else
   localparam int SELF_HIT_EXP = 0;
`endif

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge Clk) probe_d <= probe;

   initial begin
      forever begin
         exp_t e;
         int   act;
         @(negedge Clk);
         if (probe_d) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               case (e.kind)
                  0:       act = int'(bus.cell_color);
                  1:       act = int'(bus.trail_hit_blue);
                  2:       act = int'(bus.trail_hit_red);
                  default: act = int'(bus.busy);
               endcase
               check(e.name, act, e.exp);
            end
         end
      end
   end

   task automatic probe_color(input string name, input int x, input int y, input int exp);
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
      sb.push_back('{name, 0, exp});
      probe = 1'b1;
      @(posedge Clk); #1;
      probe = 1'b0;
   endtask

   task automatic probe_sig(input string name, input int kind, input int exp);
      sb.push_back('{name, kind, exp});
      probe = 1'b1;
      @(posedge Clk); #1;
      probe = 1'b0;
   endtask

   task automatic set_bikes(input int bx, input int by, input int rx, input int ry);
      bus.Blue_X = 10'(bx);
      bus.Blue_Y = 10'(by);
      bus.Red_X  = 10'(rx);
      bus.Red_Y  = 10'(ry);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (bus.busy && n < budget) begin
         @(posedge Clk); #1;
         n++;
      end
      if (bus.busy) check("idle_timeout", 1, 0);
   endtask

   task automatic do_tick;
      bus.frame_clk = 1'b1;
      repeat (3) begin @(posedge Clk); #1; end
      bus.frame_clk = 1'b0;
      repeat (4) begin @(posedge Clk); #1; end
      wait_idle(16);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.frame_clk   = 1'b0;
      bus.round_start = 1'b0;
      set_bikes(0, 0, 0, 0);
      bus.DrawX = '0;
      bus.DrawY = '0;

      // reset state
      repeat (3) begin @(posedge Clk); #1; end
      check("rst_busy", int'(bus.busy), 1);
      check("rst_hit_blue", int'(bus.trail_hit_blue), 0);
      check("rst_hit_red", int'(bus.trail_hit_red), 0);
      check("rst_cell_color", int'(bus.cell_color), 0);

      // clear sweep length
      Reset_n = 1'b1;
      n = 0;
      do begin
         @(posedge Clk); #1;
         n++;
      end while (bus.busy && n < 25000);
      check("clear_cycles", n, CELL_COUNT);

      for (int x = 0; x < PIX_W; x++) probe_color("scan_row0", x, 0, 0);
      for (int x = 0; x < PIX_W; x++) probe_color("scan_row479", x, 479, 0);

      // first stamp
      set_bikes(150, 240, 490, 240);
      do_tick();
      probe_color("blue_cell_9637", 150, 240, 1);
      probe_color("red_cell_9722", 490, 240, 2);
      probe_color("blue_cell_same", 151, 243, 1);
      probe_color("neighbour_empty", 154, 240, 0);
      probe_sig("first_hit_blue", 1, 0);
      probe_sig("first_hit_red", 2, 0);

      // own current cell is never a hit
      repeat (3) do_tick();
      probe_sig("hold_hit_blue", 1, 0);
      probe_sig("hold_hit_red", 2, 0);

      // invalid blue coordinate: red lights 1775, the cell blue's X=700 would alias onto
      set_bikes(700, 40, 60, 44);
      do_tick();
      set_bikes(700, 40, 8, 8);
      do_tick();
      probe_color("alias_cell_red", 60, 44, 2);
      probe_color("red_after_invalid_blue", 8, 8, 2);
      probe_color("draw_out_of_range", 700, 40, 0);
      probe_sig("invalid_hit_blue", 1, 0);
      probe_sig("invalid_hit_red", 2, 0);

      // blue crosses red's trail
      set_bikes(150, 240, 300, 100);
      do_tick();
      set_bikes(301, 101, 304, 100);
      bus.frame_clk = 1'b1;
      repeat (3) begin @(posedge Clk); #1; end
      check("hit_blue_during_ck_b", int'(bus.trail_hit_blue), 0);
      @(posedge Clk); #1;
      check("hit_blue_after_ck_b", int'(bus.trail_hit_blue), 1);
      bus.frame_clk = 1'b0;
      repeat (4) begin @(posedge Clk); #1; end
      wait_idle(16);
      probe_sig("cross_hit_red", 2, 0);
      probe_color("crossed_cell_now_blue", 300, 100, 1);
      repeat (2) do_tick();
      probe_sig("hit_blue_sticky", 1, 1);

      // head-on in one cell
      set_bikes(320, 200, 320, 200);
      do_tick();
      probe_sig("same_cell_hit_blue", 1, 1);
      probe_sig("same_cell_hit_red", 2, 1);
      probe_color("same_cell_8080", 320, 200, 2);

      // round_start during RD_R
      set_bikes(100, 100, 200, 100);
      bus.frame_clk = 1'b1;
      repeat (4) begin @(posedge Clk); #1; end
      bus.round_start = 1'b1;
      @(posedge Clk); #1;
      bus.round_start = 1'b0;
      bus.frame_clk   = 1'b0;
      probe_sig("abort_busy", 3, 1);
      probe_color("abort_blue_kept", 100, 100, 1);
      probe_color("abort_red_dropped", 200, 100, 0);
      wait_idle(20000);
      probe_sig("abort_hit_blue", 1, 0);
      probe_sig("abort_hit_red", 2, 0);
      probe_color("abort_cleared", 100, 100, 0);

      // blue revisits its own earlier cell
      set_bikes(40, 40, 600, 400);
      do_tick();
      set_bikes(44, 40, 600, 400);
      do_tick();
      set_bikes(40, 40, 600, 400);
      do_tick();
      probe_sig("self_cross_hit_blue", 1, SELF_HIT_EXP);
      probe_sig("self_cross_hit_red", 2, 0);
      probe_color("self_cross_cell", 40, 40, 1);

      repeat (3) begin @(posedge Clk); #1; end
      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
